// File: rtl/canvas_port_scheduler_if.sv
// Bundles the requester handshakes and the canvas BRAM port of the port scheduler.
// The master side is the requesters plus the BRAM model, and the slave side is the scheduler.
// The modports only fix signal direction; they add no logic or latency.
interface canvas_port_scheduler_if #(
    parameter int ADDR_W = 10
);
    logic              clear_req;
    logic              clear_busy;
    logic              draw_valid;
    logic [ADDR_W-1:0] draw_addr;
    logic              draw_data;
    logic              draw_ready;
    logic              win_en;
    logic [4:0]        win_x;
    logic [4:0]        win_y;
    logic              rd_valid;
    logic [ADDR_W-1:0] rd_addr;
    logic              rd_ready;
    logic              rd_data_valid;
    logic              rd_data;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_we;
    logic              mem_wdata;
    logic              mem_rdata;

    modport master (
        output clear_req, draw_valid, draw_addr, draw_data, win_en, win_x, win_y,
               rd_valid, rd_addr, mem_rdata,
        input  clear_busy, draw_ready, rd_ready, rd_data_valid, rd_data,
               mem_addr, mem_we, mem_wdata
    );

    modport slave (
        input  clear_req, draw_valid, draw_addr, draw_data, win_en, win_x, win_y,
               rd_valid, rd_addr, mem_rdata,
        output clear_busy, draw_ready, rd_ready, rd_data_valid, rd_data,
               mem_addr, mem_we, mem_wdata
    );
endinterface

// File: rtl/canvas_port_scheduler.sv
// Shares the single canvas BRAM port between the clear sweep, the stroke writer and the reader.
// Latency: the memory command is registered one cycle after the grant, and read data returns two cycles after it is accepted.
// Backpressure: the ready signals are combinational, a clear blocks both requesters, and the reader is forced through after STARVE_LIMIT lost cycles.
module canvas_port_scheduler #(
    parameter int ADDR_W       = 10,
    parameter int CELLS        = 1024,
    parameter int STARVE_LIMIT = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    canvas_port_scheduler_if.slave  bus
);
    localparam int SW = $clog2(STARVE_LIMIT + 1);

    typedef enum logic {IDLE = 1'b0, CLEAR = 1'b1} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic [SW-1:0]     starve_q, starve_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic              mem_we_q, mem_we_d;
    logic              mem_wdata_q, mem_wdata_d;
    logic              rd_pipe_q, rd_pipe_d;
    logic              rd_data_valid_q, rd_data_valid_d;
    logic              clear_busy_q, clear_busy_d;
    logic              draw_gnt, rd_gnt, win_miss;

    // A stroke outside the edit window is accepted but turned into a no-op.
    assign win_miss = bus.win_en &
                      ((bus.draw_addr[4:0] != bus.win_x) | (bus.draw_addr[9:5] != bus.win_y));

    // Decide the grant and next memory command. A clear request overrides everything.
    always_comb begin
        state_d         = state_q;
        cnt_d           = cnt_q;
        starve_d        = starve_q;
        mem_addr_d      = mem_addr_q;
        mem_we_d        = 1'b0;
        mem_wdata_d     = mem_wdata_q;
        rd_pipe_d       = 1'b0;
        draw_gnt        = 1'b0;
        rd_gnt          = 1'b0;
        if (bus.clear_req) begin
            // Start or restart the sweep. The top cell is written in the first busy cycle.
            state_d     = CLEAR;
            cnt_d       = ADDR_W'(CELLS - 1);
            mem_addr_d  = ADDR_W'(CELLS - 1);
            mem_we_d    = 1'b1;
            mem_wdata_d = 1'b0;
        end else if (state_q == CLEAR) begin
            // cnt_q is the address being written this cycle. Stop after cell 0.
            if (cnt_q == '0) begin
                state_d = IDLE;
            end else begin
                cnt_d       = cnt_q - 1'b1;
                mem_addr_d  = cnt_q - 1'b1;
                mem_we_d    = 1'b1;
                mem_wdata_d = 1'b0;
            end
        end else begin
            if (bus.draw_valid && bus.rd_valid) begin
                rd_gnt   = (starve_q == SW'(STARVE_LIMIT));
                draw_gnt = !rd_gnt;
            end else begin
                draw_gnt = bus.draw_valid;
                rd_gnt   = bus.rd_valid;
            end
            if (draw_gnt) begin
                mem_addr_d  = bus.draw_addr;
                mem_wdata_d = bus.draw_data;
                mem_we_d    = !win_miss;
            end
            if (rd_gnt) begin
                mem_addr_d = bus.rd_addr;
                rd_pipe_d  = 1'b1;
            end
        end
        // The count only grows while the reader loses to a draw. It holds during a clear.
        if (!bus.rd_valid || rd_gnt) begin
            starve_d = '0;
        end else if (draw_gnt) begin
            starve_d = starve_q + SW'(1);
        end
        rd_data_valid_d = rd_pipe_q;
        clear_busy_d    = (state_d == CLEAR);
    end

    // State and registered outputs. Reset drops the sweep and any reads in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= IDLE;
            cnt_q           <= '0;
            starve_q        <= '0;
            mem_addr_q      <= '0;
            mem_we_q        <= 1'b0;
            mem_wdata_q     <= 1'b0;
            rd_pipe_q       <= 1'b0;
            rd_data_valid_q <= 1'b0;
            clear_busy_q    <= 1'b0;
        end else begin
            state_q         <= state_d;
            cnt_q           <= cnt_d;
            starve_q        <= starve_d;
            mem_addr_q      <= mem_addr_d;
            mem_we_q        <= mem_we_d;
            mem_wdata_q     <= mem_wdata_d;
            rd_pipe_q       <= rd_pipe_d;
            rd_data_valid_q <= rd_data_valid_d;
            clear_busy_q    <= clear_busy_d;
        end
    end

    assign bus.draw_ready    = draw_gnt;
    assign bus.rd_ready      = rd_gnt;
    assign bus.clear_busy    = clear_busy_q;
    assign bus.mem_addr      = mem_addr_q;
    assign bus.mem_we        = mem_we_q;
    assign bus.mem_wdata     = mem_wdata_q;
    assign bus.rd_data_valid = rd_data_valid_q;
    // BRAM output is already in its return cycle, so it is gated by the valid flag.
    assign bus.rd_data       = rd_data_valid_q & bus.mem_rdata;
endmodule
